// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - opcodes, FSM states and default width shared by the alu_share blocks
package alu_share_pkg;

    localparam int DEF_DATA_W = 32;

    localparam logic [3:0] OP_ZERO  = 4'h0;
    localparam logic [3:0] OP_INC   = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_DEC   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_RSUB  = 4'h5;
    localparam logic [3:0] OP_MUL   = 4'h6;
    localparam logic [3:0] OP_PASSB = 4'h7;
    localparam logic [3:0] OP_AND   = 4'h8;
    localparam logic [3:0] OP_OR    = 4'h9;
    localparam logic [3:0] OP_XOR   = 4'hA;
    localparam logic [3:0] OP_NOT   = 4'hB;
    localparam logic [3:0] OP_SHL1  = 4'hC;
    localparam logic [3:0] OP_SHL_B = 4'hD;
    localparam logic [3:0] OP_SHR1  = 4'hE;
    localparam logic [3:0] OP_SHR_B = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

endpackage

// File: rtl/alu_share_alu.sv
// rtl/alu_share_alu.sv - combinational 16-op ALU datapath, results truncated to DATA_W
module alu_share_alu import alu_share_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    // Variable shifts saturate to zero once B reaches the operand width
    logic shift_oob;
    assign shift_oob = (b >= DATA_W'(DATA_W));

    always_comb begin
        y = '0;
        case (op)
            OP_ZERO:  y = '0;
            OP_INC:   y = a + DATA_W'(1);
            OP_ADD:   y = a + b;
            OP_DEC:   y = a - DATA_W'(1);
            OP_SUB:   y = a - b;
            OP_RSUB:  y = b - a;
            OP_MUL:   y = a * b;
            OP_PASSB: y = b;
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOT:   y = ~a;
            OP_SHL1:  y = a << 1;
            OP_SHL_B: y = shift_oob ? '0 : (a << b);
            OP_SHR1:  y = a >> 1;
            OP_SHR_B: y = shift_oob ? '0 : (a >> b);
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_picker.sv
// rtl/alu_share_picker.sv - N-way priority picker whose search starts at ptr and wraps
module alu_share_picker #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    int k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!any && valid[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one ALU among N_REQ requesters; ALU_SHARE_FIXED_PRI_EN selects fixed priority
module alu_share_ctrl import alu_share_pkg::*; #(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = DEF_DATA_W,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [4*N_REQ-1:0]        req_op,
    input  logic [DATA_W*N_REQ-1:0]   req_a,
    input  logic [DATA_W*N_REQ-1:0]   req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_zero,
    output logic                      busy
);

    state_t              state, state_nxt;
    logic [N_REQ-1:0]    grant;
    logic [ID_W-1:0]     gidx;
    logic                gany;
    logic [ID_W-1:0]     ptr;
    logic                accept;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   a_q, b_q, alu_y, data_q;
    logic [ID_W-1:0]     id_q;
    logic                zero_q;

`ifdef ALU_SHARE_FIXED_PRI_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + ID_W'(1);
        end
    end
`endif

    alu_share_picker #(.N_REQ(N_REQ)) u_picker (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants are suppressed while reset is held so req_ready reads 0 even with valids up
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (gany && !rst) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_ZERO;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            data_q <= '0;
            zero_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= req_op[4*int'(gidx) +: 4];
                a_q  <= req_a[DATA_W*int'(gidx) +: DATA_W];
                b_q  <= req_b[DATA_W*int'(gidx) +: DATA_W];
                id_q <= gidx;
            end
            if (state == S_EXEC) begin
                data_q <= alu_y;
                zero_q <= (alu_y == '0);
            end
        end
    end

    // The ALU only ever sees registered operands, never the live request buses
    alu_share_alu #(.DATA_W(DATA_W)) u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y)
    );

    assign rsp_id   = id_q;
    assign rsp_data = data_q;
    assign rsp_zero = zero_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - scoreboard bench for alu_share_ctrl; ALU_SHARE_FIXED_PRI_EN selects fixed-priority expectations
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready;
    logic [4*N-1:0] req_op;
    logic [W*N-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready, rsp_zero, busy;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    exp_t sb[$];
    int   exp_order[$];
    int   rsp_times[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_ctrl #(.N_REQ(N), .DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            4'h0: return 32'd0;
            4'h1: return a + 32'd1;
            4'h2: return a + b;
            4'h3: return a - 32'd1;
            4'h4: return a - b;
            4'h5: return b - a;
            4'h6: return p[31:0];
            4'h7: return b;
            4'h8: return a & b;
            4'h9: return a | b;
            4'hA: return a ^ b;
            4'hB: return ~a;
            4'hC: return {a[30:0], 1'b0};
            4'hD: return (b > 32'd31) ? 32'd0 : (a << b[4:0]);
            4'hE: return {1'b0, a[31:1]};
            default: return (b > 32'd31) ? 32'd0 : (a >> b[4:0]);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[4*i +: 4] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
        req_valid[i]     = 1'b1;
    endtask

    task automatic accept_now(input int g);
        exp_t e;
        e.id   = g;
        e.data = model(req_op[4*g +: 4], req_a[W*g +: W], req_b[W*g +: W]);
        sb.push_back(e);
        if (exp_order.size() > 0) check("grant_order", g, exp_order.pop_front());
    endtask

    task automatic collect();
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
            e = sb.pop_front();
            check("rsp_id", {30'd0, rsp_id}, e.id);
            check("rsp_data", rsp_data, e.data);
            check("rsp_zero", {31'd0, rsp_zero}, {31'd0, (e.data == 32'd0)});
        end
    endtask

    // Accepts grants and drains responses until n_rsp responses or the cycle budget runs out
    task automatic run(input int n_rsp, input int budget, input logic [N-1:0] sticky);
        int got = 0;
        int c   = 0;
        int g;
        while (got < n_rsp && c < budget) begin
            @(negedge clk);
            c++;
            g = -1;
            if (req_ready != '0) begin
                check("ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                check("ready_has_valid", {31'd0, req_valid[g]}, 32'd1);
                accept_now(g);
            end
            if (rsp_valid && rsp_ready) begin
                collect();
                rsp_times.push_back(cyc);
                got++;
            end
            @(posedge clk);
            #1;
            if (g >= 0 && !sticky[g]) req_valid[g] = 1'b0;
        end
        check("run_rsp_count", got, n_rsp);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'hF;
        @(negedge clk);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All four at once, twice: second round starts at 0 again after wrapping from 3
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < N; i++) set_req(i, OP_PASSB, $urandom, i);
            exp_order = '{0, 1, 2, 3};
            rsp_times.delete();
            run(4, 40, '0);
            for (int i = 1; i < rsp_times.size(); i++)
                check("rsp_spacing", rsp_times[i] - rsp_times[i-1], 3);
        end

        // Single request latency: accept at T, rsp_valid at T+2
        set_req(2, OP_ADD, 32'd4, 32'd2);
        @(negedge clk);
        check("lat_ready", {28'd0, req_ready}, 32'h4);
        accept_now(2);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("lat_exec_valid", {31'd0, rsp_valid}, 32'd0);
        check("lat_exec_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_resp_valid", {31'd0, rsp_valid}, 32'd1);
        collect();
        @(posedge clk);
        #1;

        // Pointer now rests at 3
`ifdef ALU_SHARE_FIXED_PRI_EN
        exp_order = '{0, 3};
`else
        exp_order = '{3, 0};
`endif
        set_req(0, OP_ADD, $urandom, $urandom);
        set_req(3, OP_XOR, $urandom, $urandom);
        run(2, 30, '0);

        // Back-pressure
        rsp_ready = 1'b0;
        set_req(1, OP_SUB, 32'd4, 32'd2);
        @(negedge clk);
        check("bp_ready", {28'd0, req_ready}, 32'h2);
        accept_now(1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        set_req(3, OP_INC, 32'd9, 32'd0);
        @(negedge clk);
        check("bp_exec_ready", {28'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_hold_data", rsp_data, 32'd2);
            check("bp_hold_ready", {28'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {31'd0, rsp_valid}, 32'd1);
        collect();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_next_ready", {28'd0, req_ready}, 32'h8);
        accept_now(3);
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        run(1, 20, '0);

        // Edge arithmetic, then every opcode with random operands
        set_req(0, OP_DEC, 32'd0, 32'd0);
        run(1, 20, '0);
        set_req(1, OP_MUL, 32'h10000, 32'h10000);
        run(1, 20, '0);
        set_req(2, OP_SHL_B, 32'd1, 32'd40);
        run(1, 20, '0);
        set_req(3, OP_SHR_B, 32'h8000_0000, 32'd32);
        run(1, 20, '0);
        set_req(0, OP_SHR_B, 32'h8000_0000, 32'd31);
        run(1, 20, '0);
        for (int op = 0; op < 16; op++) begin
            set_req(op % N, 4'(op), $urandom, $urandom_range(0, 40));
            run(1, 20, '0);
        end

        // Reset during RESP discards the response and clears the pointer
        set_req(2, OP_ADD, 32'd5, 32'd6);
        @(negedge clk);
        check("rr_ready", {28'd0, req_ready}, 32'h4);
        accept_now(2);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        check("rr_in_resp", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rr_valid_drop", {31'd0, rsp_valid}, 32'd0);
        check("rr_busy_drop", {31'd0, busy}, 32'd0);
        check("rr_data_clear", rsp_data, 32'd0);
        check("rr_id_clear", {30'd0, rsp_id}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        exp_order = '{0, 3};
        set_req(0, OP_OR, $urandom, $urandom);
        set_req(3, OP_AND, $urandom, $urandom);
        run(2, 30, '0);

        // Requester 0 held continuously valid alongside requester 3
        set_req(0, OP_INC, 32'd100, 32'd0);
        set_req(3, OP_NOT, 32'h0F0F_0F0F, 32'd0);
`ifdef ALU_SHARE_FIXED_PRI_EN
        exp_order = '{0, 0, 0, 0};
        run(4, 40, 4'b0001);
        req_valid[0] = 1'b0;
        exp_order = '{3};
        run(1, 20, '0);
`else
        exp_order = '{0, 3, 0, 0};
        run(4, 40, 4'b0001);
        req_valid[0] = 1'b0;
`endif
        repeat (3) @(posedge clk);
        check("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
